cobra_out_display: RTL and testbench
====================================

Name: cobra_out_display

Overview:
- Display back-end for the CYBERcobra core on the Nexys A7-100T.
- The core takes its input from the 16-bit switches (sw_i) and produces a 32-bit result (out_o). This block is the output end of that path.
- It captures the 32-bit result and shows it as 8 hex digits on the board's multiplexed, common-anode seven-segment display.
- It contains a scan-rate divider, a digit scan counter, a capture register and a registered hex decoder.

Parameters:
- SCAN_DIV, 100000: clock cycles each digit stays lit. Default gives 1 kHz per digit at 100 MHz. Legal range 2..2^24-1.
- DIV_W, 24: width of the divider counter. Must satisfy 2^DIV_W > SCAN_DIV.

Ports:
- clk_i  in  1  system clock; all state updates on the rising edge
- rst_i  in  1  reset, asynchronous, active-low
- data_i  in  32  value to display (connect to CYBERcobra out_o)
- load_i  in  1  1 = capture data_i on this rising edge
- shown_o  out  32  currently captured value
- an_o  out  8  digit anodes, active-low; an_o[0] = rightmost digit
- seg_o  out  7  segments, active-low; seg_o[6:0] = {g,f,e,d,c,b,a}
- dp_o  out  1  decimal point, active-low; held at 1 (off)

Behaviour:
- Reset (rst_i=0, asynchronous, takes effect immediately):
  - shown_o=0, divider cnt=0, digit index idx=0.
  - an_o=8'hFF, seg_o=7'h7F, dp_o=1.
  - All outputs hold these values while rst_i=0.
- Divider: cnt counts 0..SCAN_DIV-1 and wraps to 0. On the edge where cnt==SCAN_DIV-1, idx increments; idx 7 wraps to 0.
- Each digit is therefore active for exactly SCAN_DIV cycles. Full frame = 8*SCAN_DIV cycles.
- Capture:
  - On each edge with load_i=1, shown_o <= data_i.
  - load_i held high captures every cycle; the last captured value wins.
  - Capture never disturbs cnt or idx.
- Output register (updates every edge, one-cycle latency):
  - an_o <= ~(8'b1 << idx).
  - seg_o <= hex(shown_o[4*idx+3 -: 4]).
  - Both use the pre-edge idx and pre-edge shown_o. A newly captured value reaches seg_o one edge after capture, once its digit is active.
  - First edge after reset release: an_o=8'hFE, seg_o shows digit 0 of shown_o (7'h40 for 0).
- Hex table (seg_o, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Exactly one an_o bit is low at any time after the first post-reset edge (except digits blanked by the optional feature).
- Reset asserted mid-scan: immediate return to reset values. After release, scanning restarts at digit 0 with cnt=0.

Optional Feature:
- Macro: DISP_LZ_BLANK_EN.
- Defined: leading-zero blanking.
  - Digit i is blanked (an_o bit i = 1, seg_o = 7'h7F during its slot) when every nibble from i up to 7 of shown_o is 0, and i != 0.
  - Value 0 shows a single "0" on digit 0.
  - Scan timing is unchanged; blanked slots still last SCAN_DIV cycles.
- Undefined: all 8 digits always displayed, including leading zeros.

Test Plan:
- Reset check (SCAN_DIV=4 for all tests):
  - Hold rst_i=0 → an_o=FF, seg_o=7F, dp_o=1, shown_o=0.
  - Release → first edge gives an_o=FE, seg_o=40; an_o=FD appears 4 edges later.
- Full frame: load 0x1234ABCD → one frame of 32 cycles, in order:
  - (an FE, seg 21), (FD, 46), (FB, 03), (F7, 08)
  - (EF, 19), (DF, 30), (BF, 24), (7F, 79)
  - then wraps back to FE.
- Capture semantics:
  - load_i high for 3 cycles with 0x11111111, 0x22222222, 0x33333333 → shown_o=0x33333333.
  - Scan phase (cnt, idx) is identical to a run with no load.
- Async reset mid-frame: assert rst_i at digit 5 between edges → an_o=FF and shown_o=0 immediately, with no clock edge; after release the scan restarts at FE.
- DISP_LZ_BLANK_EN, load 0x000000A0:
  - Defined → only FE (seg 40) and FD (seg 08) lit; slots 2-7 show an_o=FF.
  - Load 0 → only FE (seg 40).
  - Undefined → all 8 digits lit, seg 40 on the zero digits.

Source files
------------

// File: rtl/cobra_out_display_if.sv
// rtl/cobra_out_display_if.sv - capture/display signal bundle for cobra_out_display
// master = CYBERcobra core side, slave = display back-end.
interface cobra_out_display_if;
  logic [31:0] data_i;
  logic        load_i;
  logic [31:0] shown_o;
  logic [7:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;

  modport master (output data_i, load_i, input shown_o, an_o, seg_o, dp_o);
  modport slave  (input data_i, load_i, output shown_o, an_o, seg_o, dp_o);
endinterface

// File: rtl/cobra_out_display.sv
// rtl/cobra_out_display.sv - 8-digit multiplexed seven-segment back-end for CYBERcobra out_o
// Optional macro DISP_LZ_BLANK_EN enables leading-zero blanking.
module cobra_out_display #(
  parameter int SCAN_DIV = 100000,
  parameter int DIV_W    = 24
) (
  input  logic                clk_i,
  input  logic                rst_i,
  cobra_out_display_if.slave  bus
);

  localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] cnt;
  logic [2:0]       idx;
  logic [31:0]      shown;
  logic [7:0]       an;
  logic [6:0]       seg;
  logic [3:0]       nib;
  logic [6:0]       hex;
  logic             blank;
`ifdef DISP_LZ_BLANK_EN
  logic [31:0]      upper;
`endif

  always_comb begin
    nib = shown[{idx, 2'b00} +: 4];
    case (nib)
      4'h0: hex = 7'h40;
      4'h1: hex = 7'h79;
      4'h2: hex = 7'h24;
      4'h3: hex = 7'h30;
      4'h4: hex = 7'h19;
      4'h5: hex = 7'h12;
      4'h6: hex = 7'h02;
      4'h7: hex = 7'h78;
      4'h8: hex = 7'h00;
      4'h9: hex = 7'h10;
      4'hA: hex = 7'h08;
      4'hB: hex = 7'h03;
      4'hC: hex = 7'h46;
      4'hD: hex = 7'h21;
      4'hE: hex = 7'h06;
      default: hex = 7'h0E;
    endcase
  end

  // A digit is blank when it and every more-significant nibble are zero; digit 0 always shows.
`ifdef DISP_LZ_BLANK_EN
  always_comb begin
    upper = shown >> {idx, 2'b00};
    blank = (idx != 3'd0) && (upper == 32'd0);
  end
`else
  always_comb blank = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt   <= '0;
      idx   <= '0;
      shown <= '0;
      an    <= 8'hFF;
      seg   <= 7'h7F;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (bus.load_i)
        shown <= bus.data_i;
      // Outputs are decoded from pre-edge idx/shown, giving one cycle of latency.
      if (blank) begin
        an  <= 8'hFF;
        seg <= 7'h7F;
      end else begin
        an  <= ~(8'b1 << idx);
        seg <= hex;
      end
    end
  end

  assign bus.shown_o = shown;
  assign bus.an_o    = an;
  assign bus.seg_o   = seg;
  assign bus.dp_o    = 1'b1;

endmodule

// File: tb/tb_cobra_out_display.sv
// tb/tb_cobra_out_display.sv - scoreboard bench for cobra_out_display with SCAN_DIV=4
module tb_cobra_out_display;
  logic clk = 1'b0;
  logic rst = 1'b0;

  cobra_out_display_if bus ();

  cobra_out_display #(.SCAN_DIV(4), .DIV_W(24)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   errors  = 0;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  function automatic exp_t model(input logic [31:0] v, input int d);
    exp_t e;
    logic [31:0] up;
    up = v >> (4 * d);
    e.an  = ~(8'h01 << d);
    e.seg = hex7(up[3:0]);
`ifdef DISP_LZ_BLANK_EN
    if (d != 0 && up == 32'd0) begin
      e.an  = 8'hFF;
      e.seg = 7'h7F;
    end
`endif
    return e;
  endfunction

  function automatic void push(input logic [7:0] an, input logic [6:0] seg, input int n);
    for (int k = 0; k < n; k++) sbq.push_back('{an: an, seg: seg});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset();
    rst = 1'b0;
    bus.load_i = 1'b0;
    bus.data_i = '0;
    tick();
  endtask

  task automatic test_reset();
    exp_t e;
    hold_reset();
    tick();
    vectors++;
    if (bus.an_o !== 8'hFF || bus.seg_o !== 7'h7F || bus.dp_o !== 1'b1 || bus.shown_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_hold: an=%h seg=%h dp=%b shown=%h, want an=ff seg=7f dp=1 shown=0",
               bus.an_o, bus.seg_o, bus.dp_o, bus.shown_o);
    end
    rst = 1'b1;
    push(8'hFE, 7'h40, 4);
    push(8'hFD, 7'h40, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      e = sbq.pop_front();
      vectors++;
      if (bus.an_o !== e.an || bus.seg_o !== e.seg || bus.dp_o !== 1'b1) begin
        errors++;
        $display("FAIL reset_release edge %0d: an=%h seg=%h dp=%b, want an=%h seg=%h dp=1",
                 i + 1, bus.an_o, bus.seg_o, bus.dp_o, e.an, e.seg);
      end
    end
  endtask

  task automatic test_full_frame();
    logic [7:0] ans [8];
    logic [6:0] segs [8];
    exp_t e;
    ans  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    segs = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};
    hold_reset();
    rst = 1'b1;
    bus.data_i = 32'h1234ABCD;
    bus.load_i = 1'b1;
    push(8'hFE, 7'h40, 1);
    push(ans[0], segs[0], 3);
    for (int d = 1; d < 8; d++) push(ans[d], segs[d], 4);
    push(8'hFE, 7'h21, 4);
    for (int i = 0; i < 36; i++) begin
      tick();
      bus.load_i = 1'b0;
      e = sbq.pop_front();
      vectors++;
      if (bus.an_o !== e.an || bus.seg_o !== e.seg) begin
        errors++;
        $display("FAIL full_frame edge %0d: an=%h seg=%h, want an=%h seg=%h",
                 i + 1, bus.an_o, bus.seg_o, e.an, e.seg);
      end
    end
  endtask

  task automatic test_capture();
    logic [31:0] vals [3];
    exp_t e;
    vals = '{32'h11111111, 32'h22222222, 32'h33333333};
    hold_reset();
    rst = 1'b1;
    push(8'hFE, 7'h40, 1);
    push(8'hFE, 7'h79, 1);
    push(8'hFE, 7'h24, 1);
    push(8'hFE, 7'h30, 1);
    push(8'hFD, 7'h30, 4);
    push(8'hFB, 7'h30, 4);
    for (int i = 0; i < 12; i++) begin
      bus.load_i = (i < 3);
      if (i < 3) bus.data_i = vals[i];
      tick();
      e = sbq.pop_front();
      vectors++;
      if (bus.an_o !== e.an || bus.seg_o !== e.seg) begin
        errors++;
        $display("FAIL capture edge %0d: an=%h seg=%h, want an=%h seg=%h",
                 i + 1, bus.an_o, bus.seg_o, e.an, e.seg);
      end
    end
    bus.load_i = 1'b0;
    vectors++;
    if (bus.shown_o !== 32'h33333333) begin
      errors++;
      $display("FAIL capture_last: shown=%h, want 33333333", bus.shown_o);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    hold_reset();
    rst = 1'b1;
    bus.data_i = 32'h1234ABCD;
    bus.load_i = 1'b1;
    tick();
    bus.load_i = 1'b0;
    for (int i = 1; i < 22; i++) tick();
    vectors++;
    if (bus.an_o !== 8'hDF || bus.seg_o !== 7'h30) begin
      errors++;
      $display("FAIL async_pre: an=%h seg=%h, want an=df seg=30", bus.an_o, bus.seg_o);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (bus.an_o !== 8'hFF || bus.seg_o !== 7'h7F || bus.shown_o !== 32'd0) begin
      errors++;
      $display("FAIL async_assert: an=%h seg=%h shown=%h, want an=ff seg=7f shown=0",
               bus.an_o, bus.seg_o, bus.shown_o);
    end
    #1 rst = 1'b1;
    push(8'hFE, 7'h40, 4);
    push(8'hFD, 7'h40, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      e = sbq.pop_front();
      vectors++;
      if (bus.an_o !== e.an || bus.seg_o !== e.seg) begin
        errors++;
        $display("FAIL async_restart edge %0d: an=%h seg=%h, want an=%h seg=%h",
                 i + 1, bus.an_o, bus.seg_o, e.an, e.seg);
      end
    end
  endtask

  task automatic test_blanking(input logic [31:0] v);
    exp_t e;
    hold_reset();
    rst = 1'b1;
    bus.data_i = v;
    bus.load_i = 1'b1;
    push(8'hFE, 7'h40, 1);
    for (int i = 2; i <= 33; i++) sbq.push_back(model(v, ((i - 1) / 4) % 8));
    for (int i = 0; i < 33; i++) begin
      tick();
      bus.load_i = 1'b0;
      e = sbq.pop_front();
      vectors++;
      if (bus.an_o !== e.an || bus.seg_o !== e.seg) begin
        errors++;
        $display("FAIL blank_%h edge %0d: an=%h seg=%h, want an=%h seg=%h",
                 v, i + 1, bus.an_o, bus.seg_o, e.an, e.seg);
      end
    end
  endtask

  initial begin
    bus.data_i = '0;
    bus.load_i = 1'b0;
    test_reset();
    test_full_frame();
    test_capture();
    test_async_reset();
    test_blanking(32'h000000A0);
    test_blanking(32'h00000000);
    test_blanking(32'h00F00001);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
